// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, ALU opcodes,
// writeback source selects and branch condition codes.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_LUI  = 4'b1010
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/exec_stage_alu.sv
// Combinational RV32I ALU; unassigned opcodes yield zero.
module exec_stage_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  alu_op_t         alu_op,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = src_b[4:0];

  // Opcode decode into the selected arithmetic/logic result
  always_comb begin
    result = {XLEN{1'b0}};
    case (alu_op)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_OR:   result = src_a | src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:  result = src_a << shamt;
      ALU_SRL:  result = src_a >> shamt;
      ALU_SRA:  result = $signed(src_a) >>> shamt;
      ALU_LUI:  result = src_b;
      default:  result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register feeding the memory stage.
module exec_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_wrE,
  input  logic [1:0]        result_srcE,
  input  logic              mem_wrE,
  input  logic              jumpE,
  input  logic              jalrE,
  input  logic              branchE,
  input  logic [2:0]        funct3E,
  input  logic [3:0]        alu_ctrlE,
  input  logic              alu_src_aE,
  input  logic              alu_src_bE,
  input  logic [XLEN-1:0]   rd1E,
  input  logic [XLEN-1:0]   rd2E,
  input  logic [XLEN-1:0]   imm_extE,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCp4E,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [XLEN-1:0]   resultW,
  input  logic [REG_AW-1:0] rdW,
  input  logic              reg_wrW,
  output logic              pc_srcE,
  output logic [XLEN-1:0]   pc_targetE,
  output logic              reg_wrM,
  output logic              mem_wrM,
  output logic [1:0]        result_srcM,
  output logic [XLEN-1:0]   ALU_resultM,
  output logic [XLEN-1:0]   wr_dataM,
  output logic [XLEN-1:0]   PCp4M,
  output logic [REG_AW-1:0] rdM
);

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_result, target_sum;
  logic            branch_cond;

  logic              reg_wr_d, reg_wr_q, mem_wr_d, mem_wr_q;
  logic [1:0]        result_src_d, result_src_q;
  logic [XLEN-1:0]   alu_result_d, alu_result_q, wr_data_d, wr_data_q, pcp4_d, pcp4_q;
  logic [REG_AW-1:0] rd_d, rd_q;

  // Operand forwarding: M beats W, loads in M are never forwarded, x0 never forwards
  always_comb begin
    fwd_a = rd1E;
    fwd_b = rd2E;
    if (reg_wr_q && (rd_q == rs1E) && (rs1E != {REG_AW{1'b0}}) && (result_src_q != RES_LOAD)) begin
      fwd_a = alu_result_q;
    end else if (reg_wrW && (rdW == rs1E) && (rs1E != {REG_AW{1'b0}})) begin
      fwd_a = resultW;
    end else begin
      fwd_a = rd1E;
    end
    if (reg_wr_q && (rd_q == rs2E) && (rs2E != {REG_AW{1'b0}}) && (result_src_q != RES_LOAD)) begin
      fwd_b = alu_result_q;
    end else if (reg_wrW && (rdW == rs2E) && (rs2E != {REG_AW{1'b0}})) begin
      fwd_b = resultW;
    end else begin
      fwd_b = rd2E;
    end
  end

  assign src_a = alu_src_aE ? PCE : fwd_a;
  assign src_b = alu_src_bE ? imm_extE : fwd_b;

  exec_stage_alu #(.XLEN(XLEN)) u_alu (
    .src_a  (src_a),
    .src_b  (src_b),
    .alu_op (alu_op_t'(alu_ctrlE)),
    .result (alu_result)
  );

  // Branch condition on forwarded register operands
  always_comb begin
    branch_cond = 1'b0;
    case (funct3E)
      F3_BEQ:  branch_cond = (fwd_a == fwd_b);
      F3_BNE:  branch_cond = (fwd_a != fwd_b);
      F3_BLT:  branch_cond = ($signed(fwd_a) < $signed(fwd_b));
      F3_BGE:  branch_cond = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: branch_cond = (fwd_a < fwd_b);
      F3_BGEU: branch_cond = (fwd_a >= fwd_b);
      default: branch_cond = 1'b0;
    endcase
  end

  assign target_sum = (jalrE ? fwd_a : PCE) + imm_extE;
  assign pc_targetE = {target_sum[XLEN-1:1], target_sum[0] & ~jalrE};
  assign pc_srcE    = jumpE | (branchE & branch_cond);

  // Next EX/MEM contents; reset overrides the incoming instruction
  always_comb begin
    if (rst) begin
      reg_wr_d     = 1'b0;
      mem_wr_d     = 1'b0;
      result_src_d = 2'b00;
      alu_result_d = {XLEN{1'b0}};
      wr_data_d    = {XLEN{1'b0}};
      pcp4_d       = {XLEN{1'b0}};
      rd_d         = {REG_AW{1'b0}};
    end else begin
      reg_wr_d     = reg_wrE;
      mem_wr_d     = mem_wrE;
      result_src_d = result_srcE;
      alu_result_d = alu_result;
      wr_data_d    = fwd_b;
      pcp4_d       = PCp4E;
      rd_d         = rdE;
    end
  end

  // EX/MEM register, no stall
  always_ff @(posedge clk) begin
    reg_wr_q     <= reg_wr_d;
    mem_wr_q     <= mem_wr_d;
    result_src_q <= result_src_d;
    alu_result_q <= alu_result_d;
    wr_data_q    <= wr_data_d;
    pcp4_q       <= pcp4_d;
    rd_q         <= rd_d;
  end

  assign reg_wrM     = reg_wr_q;
  assign mem_wrM     = mem_wr_q;
  assign result_srcM = result_src_q;
  assign ALU_resultM = alu_result_q;
  assign wr_dataM    = wr_data_q;
  assign PCp4M       = pcp4_q;
  assign rdM         = rd_q;

endmodule

// File: tb/tb_exec_stage.sv
// Directed plus randomized check of exec_stage against an arithmetic reference model.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_wrE, mem_wrE, jumpE, jalrE, branchE, alu_src_aE, alu_src_bE, reg_wrW;
  logic [1:0]  result_srcE;
  logic [2:0]  funct3E;
  logic [3:0]  alu_ctrlE;
  logic [31:0] rd1E, rd2E, imm_extE, PCE, PCp4E, resultW;
  logic [4:0]  rs1E, rs2E, rdE, rdW;
  logic        pc_srcE, reg_wrM, mem_wrM;
  logic [31:0] pc_targetE, ALU_resultM, wr_dataM, PCp4M;
  logic [1:0]  result_srcM;
  logic [4:0]  rdM;

  int checks = 0;
  int errors = 0;

  // Reference copy of the memory-stage view of the previous instruction
  logic        m_reg_wr = 1'b0, m_mem_wr = 1'b0;
  logic [1:0]  m_res_src = 2'd0;
  logic [31:0] m_alu = 32'd0, m_wd = 32'd0, m_pcp4 = 32'd0;
  logic [4:0]  m_rd = 5'd0;

  exec_stage dut (
    .clk(clk), .rst(rst), .reg_wrE(reg_wrE), .result_srcE(result_srcE), .mem_wrE(mem_wrE),
    .jumpE(jumpE), .jalrE(jalrE), .branchE(branchE), .funct3E(funct3E), .alu_ctrlE(alu_ctrlE),
    .alu_src_aE(alu_src_aE), .alu_src_bE(alu_src_bE), .rd1E(rd1E), .rd2E(rd2E),
    .imm_extE(imm_extE), .PCE(PCE), .PCp4E(PCp4E), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .resultW(resultW), .rdW(rdW), .reg_wrW(reg_wrW), .pc_srcE(pc_srcE), .pc_targetE(pc_targetE),
    .reg_wrM(reg_wrM), .mem_wrM(mem_wrM), .result_srcM(result_srcM), .ALU_resultM(ALU_resultM),
    .wr_dataM(wr_dataM), .PCp4M(PCp4M), .rdM(rdM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf_val);
    if (rs == 5'd0) return rf_val;
    if (m_reg_wr && m_rd == rs && m_res_src != 2'b01) return m_alu;
    if (reg_wrW && rdW == rs) return resultW;
    return rf_val;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return 32'(sa >>> b[4:0]);
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return int'(a) < int'(b);
      3'd5:    return int'(a) >= int'(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_e();
    rst = 1'b0; reg_wrE = 1'b0; mem_wrE = 1'b0; jumpE = 1'b0; jalrE = 1'b0; branchE = 1'b0;
    alu_src_aE = 1'b0; alu_src_bE = 1'b0; result_srcE = 2'd0; funct3E = 3'd2; alu_ctrlE = 4'd0;
    rd1E = 32'd0; rd2E = 32'd0; imm_extE = 32'd0; PCE = 32'd0; PCp4E = 32'd0;
    rs1E = 5'd0; rs2E = 5'd0; rdE = 5'd0; resultW = 32'd0; rdW = 5'd0; reg_wrW = 1'b0;
  endtask

  // Check the combinational outputs, clock one edge, then check the EX/MEM outputs
  task automatic step(input string tag);
    logic [31:0] fa, fb, sa, sb, res, tgt;
    #1;
    fa  = ref_operand(rs1E, rd1E);
    fb  = ref_operand(rs2E, rd2E);
    sa  = alu_src_aE ? PCE : fa;
    sb  = alu_src_bE ? imm_extE : fb;
    res = ref_alu(alu_ctrlE, sa, sb);
    tgt = (jalrE ? fa : PCE) + imm_extE;
    if (jalrE) tgt[0] = 1'b0;
    chk({tag, ".pc_src"}, {31'd0, pc_srcE}, {31'd0, jumpE | (branchE & ref_taken(funct3E, fa, fb))});
    chk({tag, ".pc_target"}, pc_targetE, tgt);
    if (rst) begin
      m_reg_wr = 1'b0; m_mem_wr = 1'b0; m_res_src = 2'd0;
      m_alu = 32'd0; m_wd = 32'd0; m_pcp4 = 32'd0; m_rd = 5'd0;
    end else begin
      m_reg_wr = reg_wrE; m_mem_wr = mem_wrE; m_res_src = result_srcE;
      m_alu = res; m_wd = fb; m_pcp4 = PCp4E; m_rd = rdE;
    end
    @(posedge clk);
    #1;
    chk({tag, ".reg_wrM"}, {31'd0, reg_wrM}, {31'd0, m_reg_wr});
    chk({tag, ".mem_wrM"}, {31'd0, mem_wrM}, {31'd0, m_mem_wr});
    chk({tag, ".result_srcM"}, {30'd0, result_srcM}, {30'd0, m_res_src});
    chk({tag, ".ALU_resultM"}, ALU_resultM, m_alu);
    chk({tag, ".wr_dataM"}, wr_dataM, m_wd);
    chk({tag, ".PCp4M"}, PCp4M, m_pcp4);
    chk({tag, ".rdM"}, {27'd0, rdM}, {27'd0, m_rd});
  endtask

  initial begin
    clear_e();
    // Reset held two cycles against a live store/writeback
    rst = 1'b1; reg_wrE = 1'b1; mem_wrE = 1'b1; rdE = 5'd4; rd1E = 32'h33; PCp4E = 32'h44;
    @(negedge clk);
    step("reset1");
    step("reset2");
    chk("reset.mem_wrM_zero", {31'd0, mem_wrM}, 32'd0);
    chk("reset.ALU_resultM_zero", ALU_resultM, 32'd0);

    // ADD with operand forwarded from M
    clear_e(); reg_wrE = 1'b1; rdE = 5'd5; rd1E = 32'h10; alu_src_bE = 1'b1;
    step("add_prod");
    clear_e(); rs1E = 5'd5; rd1E = 32'hDEAD; imm_extE = 32'd4; alu_src_bE = 1'b1;
    step("add_fwd_m");
    chk("add_fwd_m.lit", ALU_resultM, 32'h14);

    // M beats W on the same register
    clear_e(); reg_wrE = 1'b1; rdE = 5'd7; rd1E = 32'd1; alu_src_bE = 1'b1;
    step("prio_prod");
    clear_e(); alu_ctrlE = 4'd1; rs1E = 5'd1; rd1E = 32'd10; rs2E = 5'd7; rd2E = 32'd99;
    reg_wrW = 1'b1; rdW = 5'd7; resultW = 32'd2;
    step("prio_sub");
    chk("prio_sub.lit", ALU_resultM, 32'd9);

    // x0 never forwards, from M or from W
    clear_e(); reg_wrE = 1'b1; rdE = 5'd0; rd1E = 32'd1; alu_src_bE = 1'b1;
    step("x0_prod");
    clear_e(); alu_ctrlE = 4'd1; rs1E = 5'd1; rd1E = 32'd10; rs2E = 5'd0; rd2E = 32'd3;
    reg_wrW = 1'b1; rdW = 5'd0; resultW = 32'd2;
    step("x0_sub");
    chk("x0_sub.lit", ALU_resultM, 32'd7);

    // Load in M is skipped, W value used
    clear_e(); reg_wrE = 1'b1; result_srcE = 2'b01; rdE = 5'd3; rd1E = 32'h77; alu_src_bE = 1'b1;
    step("load_prod");
    clear_e(); rs1E = 5'd3; rd1E = 32'h11; alu_src_bE = 1'b1;
    reg_wrW = 1'b1; rdW = 5'd3; resultW = 32'h55;
    step("load_skip");
    chk("load_skip.lit", ALU_resultM, 32'h55);

    // Signed vs unsigned branches
    clear_e(); branchE = 1'b1; funct3E = 3'b100; rd1E = 32'hFFFF_FFFF; rd2E = 32'd1;
    PCE = 32'h100; imm_extE = 32'h20;
    #1;
    chk("blt.pc_src_lit", {31'd0, pc_srcE}, 32'd1);
    chk("blt.target_lit", pc_targetE, 32'h120);
    step("blt");
    funct3E = 3'b110;
    #1;
    chk("bltu.pc_src_lit", {31'd0, pc_srcE}, 32'd0);
    step("bltu");

    // JALR clears bit 0 and carries PC+4 to M
    clear_e(); jumpE = 1'b1; jalrE = 1'b1; reg_wrE = 1'b1; rdE = 5'd1; result_srcE = 2'b10;
    rd1E = 32'h203; PCE = 32'h400; PCp4E = 32'h404; alu_src_aE = 1'b1; alu_src_bE = 1'b1; alu_ctrlE = 4'd10;
    #1;
    chk("jalr.target_lit", pc_targetE, 32'h202);
    step("jalr");
    chk("jalr.PCp4M_lit", PCp4M, 32'h404);

    // Store with rs2 forwarded from M
    clear_e(); reg_wrE = 1'b1; rdE = 5'd9; alu_ctrlE = 4'd10; alu_src_bE = 1'b1; imm_extE = 32'hCAFE;
    step("store_prod");
    clear_e(); mem_wrE = 1'b1; rs1E = 5'd2; rd1E = 32'h10; rs2E = 5'd9; imm_extE = 32'hC; alu_src_bE = 1'b1;
    step("store");
    chk("store.wr_data_lit", wr_dataM, 32'hCAFE);
    chk("store.addr_lit", ALU_resultM, 32'h1C);
    chk("store.word_lit", ALU_resultM >> 2, 32'd7);

    // Reset kills an in-flight store
    clear_e(); rst = 1'b1; mem_wrE = 1'b1; reg_wrE = 1'b1; rdE = 5'd6;
    step("kill");
    chk("kill.mem_wr_lit", {31'd0, mem_wrM}, 32'd0);

    // Randomized traffic with narrow register indices to exercise forwarding
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      reg_wrE = 1'($urandom); mem_wrE = 1'($urandom); jumpE = ($urandom_range(0, 7) == 0);
      jalrE = 1'($urandom); branchE = 1'($urandom); alu_src_aE = 1'($urandom); alu_src_bE = 1'($urandom);
      result_srcE = 2'($urandom); funct3E = 3'($urandom); alu_ctrlE = 4'($urandom);
      rd1E = ($urandom_range(0, 3) == 0) ? rd2E : $urandom;
      rd2E = $urandom; imm_extE = $urandom; PCE = $urandom; PCp4E = $urandom; resultW = $urandom;
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3)); rdE = 5'($urandom_range(0, 3));
      rdW = 5'($urandom_range(0, 3)); reg_wrW = 1'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline; sits between the ID/EX register and the memory/writeback stage.
- Resolves operand forwarding from M and W, computes the ALU result, and resolves branches and jumps.
- Owns the EX/MEM pipeline register and drives all *M signals consumed by the memory stage (word address = ALU_resultM>>2).

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
reg_wrE  in  1  instruction writes rd
result_srcE  in  2  00 ALU, 01 load data, 10 PC+4
mem_wrE  in  1  store
jumpE  in  1  JAL/JALR
jalrE  in  1  target base is rs1 (else PC)
branchE  in  1  conditional branch
funct3E  in  3  branch condition select
alu_ctrlE  in  4  ALU operation
alu_src_aE  in  1  0 forwarded rs1, 1 PCE (AUIPC)
alu_src_bE  in  1  0 forwarded rs2, 1 imm_extE
rd1E, rd2E  in  XLEN  register file read data
imm_extE  in  XLEN  sign-extended immediate
PCE, PCp4E  in  XLEN  instruction PC, PC+4
rs1E, rs2E, rdE  in  REG_AW  register indices
resultW  in  XLEN  writeback-stage result
rdW  in  REG_AW  writeback destination
reg_wrW  in  1  writeback enable
pc_srcE  out  1  redirect fetch (combinational)
pc_targetE  out  XLEN  redirect target (combinational)
reg_wrM, mem_wrM  out  1  registered controls
result_srcM  out  2  registered
ALU_resultM, wr_dataM, PCp4M  out  XLEN  registered
rdM  out  REG_AW  registered

Behaviour:
- Forward A (rs1) priority: M when reg_wrM, rdM==rs1E, rs1E!=0, result_srcM!=01 -> ALU_resultM; else W when reg_wrW, rdW==rs1E, rs1E!=0 -> resultW; else rd1E. Forward B (rs2) uses the same rule with rd2E.
- Load-use hazards are stalled upstream and are never forwarded from M.
- srcA = alu_src_aE ? PCE : fwdA. srcB = alu_src_bE ? imm_extE : fwdB. wr_data = fwdB, always, including stores.
- ALU ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 pass srcB (LUI).
- Shift amount = srcB[4:0]. Add/sub wrap modulo 2^32. Undefined codes produce 0.
- Branch condition compares fwdA against fwdB, selected by funct3E: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GE-U. Other codes are never taken.
- pc_srcE = jumpE | (branchE & cond).
- pc_targetE = (jalrE ? fwdA : PCE) + imm_extE; when jalrE, bit 0 is cleared.
- EX/MEM register updates every posedge clk and has no stall. Latency E->M is 1 cycle.
- Bubbles arrive from upstream as zeroed controls. With reg_wrE=0 and mem_wrE=0, the stage still registers data but has no architectural effect.
- Reset: rst=1 at a clock edge zeroes reg_wrM, mem_wrM, result_srcM, ALU_resultM, wr_dataM, PCp4M and rdM; reset wins over any concurrent E input.
- Reset mid-operation kills the in-flight M instruction: no store and no writeback follow.
- Simultaneous M and W match on the same register: M wins. rd=x0 never forwards, so x0 reads rd1E/rd2E, which is 0 from the regfile.
- pc_srcE/pc_targetE are combinational and not gated by rst; the hazard unit masks them during reset.

Decomposition:
- Shared package riscv_pkg holds alu_op_t (4-bit enum with the codes above), result_src_t (2-bit), branch funct3 localparams, and XLEN.
- One sub-module, alu: purely combinational, inputs srcA, srcB, alu_op_t; output result.
- Forwarding, branch compare and the EX/MEM register stay in exec_stage.

Test Plan:
- Reset: hold rst=1 2 cycles with reg_wrE=1, mem_wrE=1 -> all *M outputs 0 after the edge; mem_wrM stays 0.
- ADD with M forward: a prior instruction leaves ALU_resultM=0x10, rdM=5, reg_wrM=1; next rs1E=5, rd1E=0xDEAD, imm=4, alu_src_bE=1 -> ALU_resultM=0x14.
- Forward priority: rdM=rdW=7, ALU_resultM=1, resultW=2, rs2E=7, SUB with rs1 value 10 -> 9. Same case with rdM=0 and rs2E=0 -> no forwarding, uses rd2E.
- Load not forwarded from M: result_srcM=01, rdM=3, rs1E=3, rdW=3, resultW=0x55 -> srcA=0x55.
- Branches: BLT with fwdA=0xFFFFFFFF, fwdB=1 -> pc_srcE=1. BLTU with the same operands -> pc_srcE=0. PCE=0x100, imm=0x20 -> pc_targetE=0x120.
- JALR and store: jalrE=1, fwdA=0x203, imm=0 -> pc_targetE=0x202, PCp4M=PCp4E. Store with rs2 forwarded 0xCAFE -> wr_dataM=0xCAFE, mem_wrM=1, ALU_resultM=0x1C (word 7).
